encoder_8_to_3_rr: RTL and testbench
====================================

// Module: encoder_8_to_3_rr
// PURPOSE
//  Inverse of the 3-to-8 decoder: collects up to 8 request lines and emits one 3-bit index per transfer.
//  Requests are latched as sticky pending bits and served round-robin over a valid/ready output.
//  Used in the CPU lab to turn multi-hot event/interrupt lines into a binary source id for the core.
//  Sequential: pending register, round-robin pointer, 2-state output FSM.
// PARAMETERS
//  N  8  number of request lines (fixed at 8 for this lab; kept for readability only)
//  W  3  index width, $clog2(N)
// PORTS
//  clk        input   1  single clock, all state updates on posedge
//  rst        input   1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
//  ena        input   1  request capture enable; when 0, req is ignored (draining continues)
//  req        input   N  multi-hot request lines, level-sampled each cycle
//  out_valid  output  1  out_index holds a served request
//  out_ready  input   1  consumer accepts out_index when out_valid & out_ready at posedge
//  out_index  output  W  binary index of the served request line
//  busy       output  1  |pending | out_valid
// BEHAVIOUR
//  Reset (rst==0 at posedge): pending=0, last=N-1, FSM=IDLE, out_valid=0, out_index=0, busy=0.
//   Reset mid-operation discards all pending and any un-accepted output; no transfer completes that cycle.
//  Capture: each posedge with ena=1, pending <= (pending & ~clr) | req. Set beats clear on the same bit.
//  Selection (combinational): first set bit of pending searched from (last+1) mod N upward, wrapping.
//   The grant bit is clr; last <= granted index when a load occurs.
//  FSM IDLE: out_valid=0. If pending!=0 -> load out_index=grant, clear that bit, go VALID.
//  FSM VALID: out_valid=1; out_index and out_valid held stable while out_ready=0.
//   On out_valid & out_ready: if pending!=0, load next grant in the same edge (back-to-back, stays VALID);
//   else go IDLE.
//  Latency: req at edge t -> pending at t -> out_valid at edge t+1 (1 cycle after capture, no bypass).
//  Throughput: 1 index per cycle while out_ready=1 and pending!=0.
//  Re-request of the index currently in out_index re-pends it; it is served again after one rotation.
//  Line held high continuously: re-pends every cycle; round-robin still serves every other pending line
//   before repeating it (no starvation).
//  pending==0 and out_ready toggling while IDLE: no effect.
//  Widths: index arithmetic is mod N; (last+1) wraps 7 -> 0; no other arithmetic.
// STRUCTURE
//  Package encoder_pkg: localparam N=8, W=3; typedef enum logic {S_IDLE, S_VALID} enc_state_t.
//  Sub-module rr_pick_8 (combinational): inputs pending[N], last[W]; outputs any, grant_idx[W], grant_1hot[N].
//  Top holds pending, last, state and out_index registers plus the FSM.
// TESTING
//  1 Reset: rst=0 for 2 cycles with req=8'hFF -> out_valid=0, busy=0, out_index=0 throughout.
//  2 Single: req=8'h20 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_index=5; then IDLE, busy=0.
//  3 Round-robin: req=8'h89 for 1 cycle, out_ready=1 -> indices 0,3,7 on 3 consecutive cycles.
//  4 Backpressure: req=8'h06, out_ready=0 for 4 cycles -> out_index=1 held stable; release -> 1 then 2.
//  5 Fairness: req[2] held high and req[6] pulsed, out_ready=1 -> 2 and 6 alternate; 6 not starved.
//  6 ena/reset: ena=0 with req=8'h10 -> no out_valid; ena=1, pend 8'h0F, assert rst mid-drain -> all cleared next cycle, out_valid=0.

Source files
------------

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared sizes and FSM state type for the round-robin 8-to-3 encoder
package encoder_pkg;
  localparam int N = 8;
  localparam int W = 3;
  typedef enum logic {S_IDLE, S_VALID} enc_state_t;
endpackage

// File: rtl/rr_pick_8.sv
// rr_pick_8: combinational round-robin picker, first set bit of pending after last (wrapping)
// Ports: pending[N] candidate bits, last[W] previously granted index,
//        any = pending nonzero, grant_idx[W] chosen index, grant_1hot[N] chosen bit
module rr_pick_8
  import encoder_pkg::*;
(
  input  logic [N-1:0] pending,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_1hot
);
  always_comb begin
    any = |pending;
    grant_idx = '0;
    // Walk offsets from farthest to nearest so the nearest set bit after last wins; offset N is last itself.
    for (int i = N; i > 0; i--)
      if (pending[last + W'(i)]) grant_idx = last + W'(i);
    grant_1hot = any ? N'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/encoder_8_to_3_rr.sv
// encoder_8_to_3_rr: sticky multi-hot requests served round-robin as 3-bit indices over valid/ready
// Ports: clk, rst (sync active-low), ena (request capture enable), req[N] multi-hot requests,
//        out_valid/out_ready/out_index[W] served-index handshake, busy = pending work or output held
module encoder_8_to_3_rr
  import encoder_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_index,
  output logic         busy
);
  enc_state_t r_state, w_state_next;
  logic [N-1:0] r_pending, w_grant_1hot, w_clr;
  logic [W-1:0] r_last, r_index, w_grant_idx;
  logic w_any, w_fire, w_load;
  rr_pick_8 u_pick (
    .pending(r_pending),
    .last(r_last),
    .any(w_any),
    .grant_idx(w_grant_idx),
    .grant_1hot(w_grant_1hot)
  );
  // The output slot frees when idle or when the held index is accepted; a free slot refills from pending.
  always_comb begin
    w_fire = (r_state == S_IDLE) | out_ready;
    w_load = w_fire & w_any;
    w_clr = w_load ? w_grant_1hot : '0;
    w_state_next = w_fire ? (w_any ? S_VALID : S_IDLE) : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pending <= '0;
      r_last <= W'(N - 1);
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_pending <= (r_pending & ~w_clr) | (ena ? req : '0);
      if (w_load) begin
        r_index <= w_grant_idx;
        r_last <= w_grant_idx;
      end
    end
  end
  assign out_valid = r_state == S_VALID;
  assign out_index = r_index;
  assign busy = |r_pending | out_valid;
endmodule

// File: tb/tb_encoder_8_to_3_rr.sv
// tb_encoder_8_to_3_rr: scenario tasks plus randomized traffic checked against a behavioural model
module tb_encoder_8_to_3_rr;
  logic clk = 0, rst = 0, ena = 1, out_ready = 1;
  logic [7:0] req = 0;
  logic out_valid, busy;
  logic [2:0] out_index;
  int errors = 0, checks = 0;

  encoder_8_to_3_rr dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: a set of pending lines, the last served line, and one output slot.
  logic [7:0] m_pend;
  int m_last, m_idx, m_g;
  logic m_valid, m_fire, m_busy;

  function automatic int pick(logic [7:0] p, int last);
    for (int k = 1; k <= 8; k++)
      if (p[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction

  assign m_g = pick(m_pend, m_last);
  assign m_fire = !m_valid || out_ready;
  assign m_busy = (m_pend != 0) || m_valid;

  always @(posedge clk) begin
    if (!rst) begin
      m_pend <= 0;
      m_last <= 7;
      m_valid <= 0;
      m_idx <= 0;
    end else begin
      if (m_fire) begin
        if (m_g >= 0) begin
          m_idx <= m_g;
          m_last <= m_g;
          m_valid <= 1;
        end else m_valid <= 0;
      end
      m_pend <= (m_pend & ~((m_fire && m_g >= 0) ? (8'd1 << m_g) : 8'd0)) | (ena ? req : 8'd0);
    end
  end

  task automatic apply_reset();
    rst = 0; req = 0; ena = 1; out_ready = 1;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; ena = 1; req = 8'hFF; out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy, out_index} !== 5'b0) begin
        errors++;
        $display("FAIL reset c%0d: valid/busy/idx got %b/%b/%0d want 0/0/0", c, out_valid, busy, out_index);
      end
      checks++;
      if ({out_valid, out_index, busy} !== {m_valid, 3'(m_idx), m_busy}) begin
        errors++;
        $display("FAIL reset_model c%0d: got %b/%0d/%b want %b/%0d/%b", c, out_valid, out_index, busy, m_valid, m_idx, m_busy);
      end
    end
    rst = 1; req = 0;
  endtask

  task automatic test_single();
    logic ev[3] = '{0, 1, 0};
    logic eb[3] = '{1, 1, 0};
    apply_reset();
    req = 8'h20; out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req = 0;
      checks++;
      if (out_valid !== ev[c] || busy !== eb[c] || (ev[c] && out_index !== 3'd5)) begin
        errors++;
        $display("FAIL single c%0d: valid/busy/idx got %b/%b/%0d want %b/%b/5", c, out_valid, busy, out_index, ev[c], eb[c]);
      end
      checks++;
      if ({out_valid, out_index, busy} !== {m_valid, 3'(m_idx), m_busy}) begin
        errors++;
        $display("FAIL single_model c%0d: got %b/%0d/%b want %b/%0d/%b", c, out_valid, out_index, busy, m_valid, m_idx, m_busy);
      end
    end
  endtask

  task automatic test_round_robin();
    logic ev[5] = '{0, 1, 1, 1, 0};
    int ei[5] = '{0, 0, 3, 7, 0};
    apply_reset();
    req = 8'h89; out_ready = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      req = 0;
      checks++;
      if (out_valid !== ev[c] || (ev[c] && out_index !== 3'(ei[c]))) begin
        errors++;
        $display("FAIL round_robin c%0d: valid/idx got %b/%0d want %b/%0d", c, out_valid, out_index, ev[c], ei[c]);
      end
      checks++;
      if ({out_valid, out_index, busy} !== {m_valid, 3'(m_idx), m_busy}) begin
        errors++;
        $display("FAIL round_robin_model c%0d: got %b/%0d/%b want %b/%0d/%b", c, out_valid, out_index, busy, m_valid, m_idx, m_busy);
      end
    end
  endtask

  task automatic test_backpressure();
    logic ev[7] = '{0, 1, 1, 1, 1, 1, 0};
    int ei[7] = '{0, 1, 1, 1, 1, 2, 0};
    apply_reset();
    req = 8'h06; out_ready = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      req = 0;
      checks++;
      if (out_valid !== ev[c] || (ev[c] && out_index !== 3'(ei[c]))) begin
        errors++;
        $display("FAIL backpressure c%0d: valid/idx got %b/%0d want %b/%0d", c, out_valid, out_index, ev[c], ei[c]);
      end
      checks++;
      if ({out_valid, out_index, busy} !== {m_valid, 3'(m_idx), m_busy}) begin
        errors++;
        $display("FAIL backpressure_model c%0d: got %b/%0d/%b want %b/%0d/%b", c, out_valid, out_index, busy, m_valid, m_idx, m_busy);
      end
      if (c == 4) out_ready = 1;
    end
  endtask

  task automatic test_fairness();
    int seen6 = 0;
    apply_reset();
    req = 8'h44; out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req = (c < 6) ? 8'h04 : 8'h00;
      if (out_valid && out_index == 3'd6) seen6++;
      if (c == 1 || c == 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_index !== (c == 1 ? 3'd2 : 3'd6)) begin
          errors++;
          $display("FAIL fairness c%0d: valid/idx got %b/%0d want 1/%0d", c, out_valid, out_index, c == 1 ? 2 : 6);
        end
      end
      checks++;
      if ({out_valid, out_index, busy} !== {m_valid, 3'(m_idx), m_busy}) begin
        errors++;
        $display("FAIL fairness_model c%0d: got %b/%0d/%b want %b/%0d/%b", c, out_valid, out_index, busy, m_valid, m_idx, m_busy);
      end
    end
    checks++;
    if (seen6 !== 1) begin
      errors++;
      $display("FAIL fairness_served6: got %0d want 1", seen6);
    end
  endtask

  task automatic test_ena_reset();
    apply_reset();
    ena = 0; req = 8'h10; out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ena_off c%0d: valid/busy got %b/%b want 0/0", c, out_valid, busy);
      end
    end
    ena = 1; req = 8'h0F;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      req = 0;
      checks++;
      if (c == 1 && (out_valid !== 1'b1 || out_index !== 3'd0)) begin
        errors++;
        $display("FAIL drain c%0d: valid/idx got %b/%0d want 1/0", c, out_valid, out_index);
      end
      if (c == 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_index !== 3'd1) begin
          errors++;
          $display("FAIL drain c%0d: valid/idx got %b/%0d want 1/1", c, out_valid, out_index);
        end
        rst = 0;
      end
      if (c >= 3) begin
        checks++;
        if ({out_valid, busy, out_index} !== 5'b0) begin
          errors++;
          $display("FAIL mid_reset c%0d: valid/busy/idx got %b/%b/%0d want 0/0/0", c, out_valid, busy, out_index);
        end
        rst = 1;
      end
      if ({out_valid, out_index, busy} !== {m_valid, 3'(m_idx), m_busy}) begin
        errors++;
        $display("FAIL ena_reset_model c%0d: got %b/%0d/%b want %b/%0d/%b", c, out_valid, out_index, busy, m_valid, m_idx, m_busy);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      req = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ena = $urandom_range(0, 7) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      rst = $urandom_range(0, 99) != 0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_index, busy} !== {m_valid, 3'(m_idx), m_busy}) begin
        errors++;
        $display("FAIL random c%0d: valid/idx/busy got %b/%0d/%b want %b/%0d/%b", c, out_valid, out_index, busy, m_valid, m_idx, m_busy);
      end
    end
    rst = 1; req = 0; ena = 1; out_ready = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_ena_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
